// File: rtl/bit_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package bit_serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/bit_serial_subtractor_cell.sv
// Combinational one-bit full subtractor: D = A ^ B ^ Bin, borrow-out when A < B + Bin.
module one_bit_full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Sequential subtractor computing a - b - bin one bit per clock, LSB first,
// with a start/busy/done handshake toward the controlling FSM.
module bit_serial_subtractor
  import bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q;
  logic [WIDTH-2:0]   res_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               borrow_q;
  logic               a_msb_q, b_msb_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q, overflow_q;

  logic               accept;
  logic               last;
  logic               cell_d, cell_bout;
  logic [WIDTH-1:0]   shifted;

  // start is only honoured when no operation is in flight
  assign accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last    = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  assign shifted = {cell_d, res_q};

  one_bit_full_subtractor u_cell (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bin_i  (borrow_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last)   state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      borrow_q   <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      a_sh_q   <= a;
      b_sh_q   <= b;
      borrow_q <= bin;
      cnt_q    <= '0;
      a_msb_q  <= a[WIDTH-1];
      b_msb_q  <= b[WIDTH-1];
    end else if (state_q == ST_RUN) begin
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      borrow_q <= cell_bout;
      res_q    <= shifted[WIDTH-1:1];
      cnt_q    <= cnt_q + 1'b1;
      // the bit produced on the last edge is the result MSB
      if (last) begin
        diff_q     <= shifted;
        bout_q     <= cell_bout;
        overflow_q <= (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
      end
    end
  end

  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed bench for bit_serial_subtractor with hand-computed expected results.
module tb_bit_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout, overflow;
  logic [W-1:0] diff;

  int checks   = 0;
  int failures = 0;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Pulses start across one rising edge; returns at the following falling edge.
  task automatic issue_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
    @(negedge clk);
    a = av; b = bv; bin = bv_in; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done is seen, bounded at 20.
  task automatic wait_done(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (lat < 20) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bout, overflow} !== 4'b0000 || diff !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b bout=%b ovf=%b diff=%h expected all zero",
               busy, done, bout, overflow, diff);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[5]  = '{8'd100, 8'd5,   8'h80, 8'h7F, 8'h00};
    logic [W-1:0] vb[5]  = '{8'd37,  8'd9,   8'h01, 8'hFF, 8'h00};
    logic         vbi[5] = '{1'b0,   1'b0,   1'b0,  1'b0,  1'b1};
    logic [W-1:0] ed[5]  = '{8'd63,  8'hFC,  8'h7F, 8'h80, 8'hFF};
    logic         eb[5]  = '{1'b0,   1'b1,   1'b0,  1'b1,  1'b1};
    logic         eo[5]  = '{1'b0,   1'b0,   1'b1,  1'b1,  1'b0};
    int lat;
    bit seen;
    for (int i = 0; i < 5; i++) begin
      issue_start(va[i], vb[i], vbi[i]);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d_busy: got busy=%b done=%b expected 1 0", i, busy, done);
      end
      wait_done(lat, seen);
      checks++;
      if (!seen || lat != W) begin
        failures++;
        $display("FAIL vec%0d_latency: got seen=%0d lat=%0d expected lat=%0d", i, seen, lat, W);
      end
      checks++;
      if (diff !== ed[i] || bout !== eb[i] || overflow !== eo[i] || busy !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d_result: got diff=%h bout=%b ovf=%b busy=%b expected diff=%h bout=%b ovf=%b busy=0",
                 i, diff, bout, overflow, busy, ed[i], eb[i], eo[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== ed[i]) begin
        failures++;
        $display("FAIL vec%0d_pulse: got done=%b busy=%b diff=%h expected 0 0 %h",
                 i, done, busy, diff, ed[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, extra;
    bit seen;
    issue_start(8'h00, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    a = 8'h55; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, seen);
    checks++;
    if (!seen || lat + 3 != W) begin
      failures++;
      $display("FAIL ignore_latency: got seen=%0d lat=%0d expected lat=%0d", seen, lat + 3, W);
    end
    checks++;
    if (diff !== 8'hFF || bout !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result: got diff=%h bout=%b ovf=%b expected ff 1 0", diff, bout, overflow);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || diff !== 8'hFF) begin
      failures++;
      $display("FAIL ignore_single_done: got extra_cycles=%0d diff=%h expected 0 ff", extra, diff);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit seen;
    issue_start(8'd200, 8'd50, 1'b0);
    wait_done(lat, seen);
    checks++;
    if (!seen || diff !== 8'd150 || bout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: got seen=%0d diff=%0d bout=%b ovf=%b expected 150 0 0",
               seen, diff, bout, overflow);
    end
    a = 8'd10; b = 8'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || diff !== 8'd150) begin
      failures++;
      $display("FAIL b2b_restart: got busy=%b done=%b diff=%0d expected 1 0 150", busy, done, diff);
    end
    wait_done(lat, seen);
    checks++;
    if (!seen || lat != W || diff !== 8'd7 || bout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: got seen=%0d lat=%0d diff=%0d bout=%b ovf=%b expected lat=%0d 7 0 0",
               seen, lat, diff, bout, overflow, W);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, pulses;
    bit seen;
    // leave nonzero diff/bout/overflow so the reset has something to clear
    issue_start(8'h7F, 8'hFF, 1'b0);
    wait_done(lat, seen);
    checks++;
    if (!seen || diff !== 8'h80 || bout !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL rst_setup: got seen=%0d diff=%h bout=%b ovf=%b expected 80 1 1",
               seen, diff, bout, overflow);
    end
    issue_start(8'hAA, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bout, overflow} !== 4'b0000 || diff !== 8'h00) begin
      failures++;
      $display("FAIL rst_async: got busy=%b done=%b bout=%b ovf=%b diff=%h expected all zero",
               busy, done, bout, overflow, diff);
    end
    pulses = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL rst_no_done: got active_cycles=%0d expected 0", pulses);
    end
    issue_start(8'h30, 8'h10, 1'b0);
    wait_done(lat, seen);
    checks++;
    if (!seen || lat != W || diff !== 8'h20 || bout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_recover: got seen=%0d lat=%0d diff=%h bout=%b ovf=%b expected lat=%0d 20 0 0",
               seen, lat, diff, bout, overflow, W);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
